// File: rtl/filt_seq_ctrl.sv
// filt_seq_ctrl: sequencing controller for the equalizer FIR bands.
// Owns the circular sample-buffer pointers, waits until a full tap window
// has been written, then runs one NTAPS-cycle read burst per accepted sample
// followed by a one-cycle out_vld strobe for capturing the band outputs.
module filt_seq_ctrl #(
  parameter int NTAPS = 1021,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          smpl_vld,
  input  logic          flush,
  input  logic          clr_ovr,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic          sequencing,
  output logic          out_vld,
  output logic          busy,
  output logic          overrun
);

  // Counter width must hold the saturated fill value NTAPS itself.
  localparam int CW = $clog2(NTAPS + 1);
  localparam logic [CW-1:0] NTAPS_C  = CW'(NTAPS);
  localparam logic [CW-1:0] LAST_TAP = CW'(NTAPS - 1);
  // When NTAPS == 2^AW this truncates to 0, which is still the right
  // modular offset for locating the oldest sample of the window.
  localparam logic [AW-1:0] NTAPS_A  = AW'(NTAPS);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    IDLE = 2'd1,
    SEQ  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fill_cnt_q, fill_cnt_d;
  logic [CW-1:0] tap_cnt_q, tap_cnt_d;
  logic          overrun_q, overrun_d;
  logic          accept;
  logic          busy_st;

  logic [AW-1:0] wr_ptr_inc;
  logic [AW-1:0] win_start;
  logic [CW-1:0] fill_inc;

  // Pointer arithmetic shared by the FILL and IDLE transitions; wraps mod 2^AW.
  assign wr_ptr_inc = wr_ptr_q + 1'b1;
  assign win_start  = wr_ptr_inc - NTAPS_A;
  assign fill_inc   = fill_cnt_q + 1'b1;
  assign busy_st    = (state_q == SEQ) || (state_q == DONE);

  // State and counter registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FILL;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_cnt_q <= '0;
      tap_cnt_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      tap_cnt_q  <= tap_cnt_d;
      overrun_q  <= overrun_d;
    end
  end

  // Next-state logic: flush wins over everything, otherwise walk the FSM.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_cnt_d = fill_cnt_q;
    tap_cnt_d  = tap_cnt_q;
    accept     = 1'b0;

    if (flush) begin
      state_d    = FILL;
      wr_ptr_d   = '0;
      fill_cnt_d = '0;
      tap_cnt_d  = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (smpl_vld) begin
            accept     = 1'b1;
            wr_ptr_d   = wr_ptr_inc;
            fill_cnt_d = fill_inc;
            if (fill_inc == NTAPS_C) begin
              state_d  = SEQ;
              rd_ptr_d = win_start;
            end
          end
        end
        IDLE: begin
          if (smpl_vld) begin
            accept   = 1'b1;
            wr_ptr_d = wr_ptr_inc;
            rd_ptr_d = win_start;
            state_d  = SEQ;
          end
        end
        SEQ: begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (tap_cnt_q == LAST_TAP) begin
            tap_cnt_d = '0;
            state_d   = DONE;
          end else begin
            tap_cnt_d = tap_cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end
  end

  // Sticky overrun: a new drop beats a simultaneous clear; flush leaves it alone.
  always_comb begin
    overrun_d = overrun_q;
    if (smpl_vld && !flush && busy_st) begin
      overrun_d = 1'b1;
    end else if (clr_ovr) begin
      overrun_d = 1'b0;
    end
  end

  // Outputs: all decoded from registers except wr_en, which follows
  // smpl_vld combinationally but is forced low while reset is asserted.
  assign wr_en      = accept & ~rst;
  assign wr_addr    = wr_ptr_q;
  assign rd_addr    = rd_ptr_q;
  assign sequencing = (state_q == SEQ);
  assign out_vld    = (state_q == DONE);
  assign busy       = busy_st;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_filt_seq_ctrl.sv
// Testbench for filt_seq_ctrl: randomized and directed stimulus, a
// time-based reference model, and a scoreboard/monitor pair.
module tb_filt_seq_ctrl;

  localparam int NTAPS = 1021;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          smpl_vld = 1'b0;
  logic          flush = 1'b0;
  logic          clr_ovr = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          sequencing;
  logic          out_vld;
  logic          busy;
  logic          overrun;

  always #5 clk = ~clk;

  filt_seq_ctrl #(.NTAPS(NTAPS), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .smpl_vld   (smpl_vld),
    .flush      (flush),
    .clr_ovr    (clr_ovr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .rd_addr    (rd_addr),
    .sequencing (sequencing),
    .out_vld    (out_vld),
    .busy       (busy),
    .overrun    (overrun)
  );

  typedef struct {
    logic          seq;
    logic          ovld;
    logic          bsy;
    logic          ovr;
    logic          wen;
    logic [AW-1:0] waddr;
  } stat_t;

  stat_t sq[$];   // expected per-cycle status
  int    wq[$];   // expected write addresses
  int    bq[$];   // expected burst start addresses

  int checks = 0;
  int errors = 0;

  // Reference model: a burst is described by the cycle of the write that
  // started it (m_bt) and the last cycle it is allowed to live (m_kill).
  int cyc    = 0;
  int m_wp   = 0;
  int m_fill = 0;
  int m_bt   = -100000;
  int m_kill = 0;
  bit m_ovr  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_seq_at(input int c);
    return (c >= m_bt + 1) && (c <= m_bt + NTAPS) && (c <= m_kill);
  endfunction

  function automatic bit m_ovld_at(input int c);
    return (c == m_bt + NTAPS + 1) && (c <= m_kill);
  endfunction

  // One clock cycle of stimulus; records what the DUT should show this cycle.
  task automatic step(input bit s, input bit f, input bit c, input bit r = 1'b0);
    stat_t st;
    bit    ms, mo, mb, acc;
    @(posedge clk);
    #1;
    cyc++;
    smpl_vld = s;
    flush    = f;
    clr_ovr  = c;
    rst      = r;
    if (r) begin
      st.seq = 1'b0; st.ovld = 1'b0; st.bsy = 1'b0;
      st.ovr = 1'b0; st.wen = 1'b0; st.waddr = '0;
      sq.push_back(st);
      m_wp = 0; m_fill = 0; m_bt = -100000; m_kill = 0; m_ovr = 1'b0;
      bq.delete();
      #1;
      chk("rst_async_sequencing", sequencing, 0);
      chk("rst_async_out_vld", out_vld, 0);
      chk("rst_async_busy", busy, 0);
      chk("rst_async_overrun", overrun, 0);
      chk("rst_async_wr_en", wr_en, 0);
      chk("rst_async_wr_addr", wr_addr, 0);
      chk("rst_async_rd_addr", rd_addr, 0);
      return;
    end
    ms  = m_seq_at(cyc);
    mo  = m_ovld_at(cyc);
    mb  = ms || mo;
    acc = s && !f && !mb;
    st.seq = ms; st.ovld = mo; st.bsy = mb; st.ovr = m_ovr;
    st.wen = acc; st.waddr = m_wp[AW-1:0];
    sq.push_back(st);
    if (acc) begin
      wq.push_back(m_wp);
      m_wp = (m_wp + 1) % DEPTH;
      if (m_fill < NTAPS) m_fill++;
      if (m_fill == NTAPS) begin
        m_bt   = cyc;
        m_kill = 1 << 30;
        bq.push_back((m_wp - NTAPS + DEPTH) % DEPTH);
      end
    end
    if (s && !f && mb) m_ovr = 1'b1;
    else if (c) m_ovr = 1'b0;
    if (f) begin
      m_wp   = 0;
      m_fill = 0;
      if (cyc <= m_bt + NTAPS && cyc <= m_kill && bq.size() > 0) void'(bq.pop_back());
      if (cyc < m_kill) m_kill = cyc;
    end
  endtask

  task automatic idle_until_free();
    for (int n = 0; n < 2 * NTAPS + 10; n++) begin
      if (!(m_seq_at(cyc + 1) || m_ovld_at(cyc + 1))) break;
      step(1'b0, 1'b0, 1'b0);
    end
  endtask

  // Monitor: compares status every cycle, write addresses on wr_en and
  // read-address sequences / burst lengths around sequencing and out_vld.
  bit in_b    = 1'b0;
  int b_start = 0;
  int b_k     = 0;

  always @(negedge clk) begin
    stat_t st;
    int    ea;
    if (sq.size() > 0) begin
      st = sq.pop_front();
      chk("sequencing", sequencing, st.seq);
      chk("out_vld", out_vld, st.ovld);
      chk("busy", busy, st.bsy);
      chk("overrun", overrun, st.ovr);
      chk("wr_en", wr_en, st.wen);
      chk("wr_addr_reg", wr_addr, st.waddr);
    end
    if (wr_en === 1'b1) begin
      chk("wr_expected", wq.size() != 0, 1);
      if (wq.size() != 0) begin
        ea = wq.pop_front();
        chk("wr_addr", wr_addr, ea);
      end
    end
    if (sequencing === 1'b1 && !in_b) begin
      chk("burst_expected", bq.size() != 0, 1);
      b_start = (bq.size() != 0) ? bq[0] : -1;
      b_k     = 0;
      in_b    = 1'b1;
    end
    if (sequencing === 1'b1 && in_b) begin
      chk("rd_addr", rd_addr, (b_start + b_k) % DEPTH);
      b_k++;
    end
    if (out_vld === 1'b1) begin
      chk("burst_len", b_k, NTAPS);
      if (bq.size() != 0) void'(bq.pop_front());
      b_k = 0;
    end
    if (sequencing !== 1'b1) in_b = 1'b0;
  end

  initial begin
    int t_end;
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Fill: 1020 pulses four cycles apart, no burst yet.
    for (int i = 0; i < NTAPS - 1; i++) begin
      step(1'b1, 1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b0);
    end

    // First burst, with a dropped sample at T+500 and a later clear.
    step(1'b1, 1'b0, 1'b0);
    repeat (499) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (600) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Random traffic: back-to-back bursts, overruns, clears, pointer wrap.
    for (int i = 0; i < 10000; i++)
      step($urandom_range(0, 7) == 0, 1'b0, $urandom_range(0, 63) == 0);

    // Flush 300 cycles into a burst, then a sample coincident with flush.
    idle_until_free();
    step(1'b1, 1'b0, 1'b0);
    repeat (299) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);

    // Refill from scratch: 1020 samples give no burst, the 1021st does.
    for (int i = 0; i < NTAPS - 1; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0);

    // Reset 600 cycles into that burst, then behave as from fresh reset.
    repeat (599) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 1) == 1, 1'b0, $urandom_range(0, 31) == 0);

    idle_until_free();
    repeat (4) step(1'b0, 1'b0, 1'b0);
    t_end = 0;
    while (sq.size() != 0 && t_end < 10) begin
      @(posedge clk);
      t_end++;
    end
    chk("status_drained", sq.size(), 0);
    chk("writes_drained", wq.size(), 0);
    chk("bursts_drained", bq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/filt_seq_ctrl.md
# filt_seq_ctrl

Sequencing controller for the equalizer FIR bands. Owns the circular sample buffer pointers, counts samples until the buffer holds a full tap window, then drives one `sequencing` burst of exactly NTAPS cycles per accepted sample. It also generates the read addresses for the buffer and a one-cycle `out_vld` strobe that tells the band outputs to be captured. The buffer RAM, the filter bands and their coefficient ROMs sit outside this block.

## Interface
- NTAPS, 1021, number of filter taps; the length of each sequencing burst.
- AW, 10, buffer address width; the buffer holds 2^AW entries. NTAPS ≤ 2^AW is required.

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- smpl_vld  in  1  one-cycle pulse: a new left/right sample pair is present at the buffer write port
- flush  in  1  synchronous clear of buffer state, takes priority over smpl_vld
- clr_ovr  in  1  synchronous clear of `overrun`
- wr_en  out  1  buffer write enable (combinational: smpl_vld & accepted)
- wr_addr  out  AW  buffer write address (registered write pointer)
- rd_addr  out  AW  buffer read address; valid while `sequencing`=1
- sequencing  out  1  high for exactly NTAPS consecutive cycles per burst
- out_vld  out  1  one-cycle strobe after a completed burst
- busy  out  1  high in SEQ or DONE
- overrun  out  1  sticky flag: a sample arrived while busy

## Operation
- States: FILL, IDLE, SEQ, DONE. The reset state is FILL.
- Registers: wr_ptr (AW bits), rd_ptr (AW bits), fill_cnt (saturates at NTAPS), tap_cnt (counts 0..NTAPS-1).
- FILL: smpl_vld causes a write at wr_ptr, then wr_ptr+1 and fill_cnt+1. When the write brings fill_cnt to NTAPS, go to SEQ and load rd_ptr = (wr_ptr+1) − NTAPS mod 2^AW, which is the oldest sample in the window. Otherwise stay in FILL.
- IDLE: smpl_vld causes a write and wr_ptr+1, then go to SEQ with rd_ptr loaded as above.
- SEQ: `sequencing`=1 and rd_addr = rd_ptr. rd_ptr+1 and tap_cnt+1 each cycle. rd_ptr wraps modulo 2^AW. When tap_cnt = NTAPS−1, go to DONE and clear tap_cnt.
- DONE: `out_vld`=1 for one cycle, then go to IDLE.
- smpl_vld in SEQ or DONE: the sample is dropped (wr_en=0, wr_ptr unchanged) and overrun is set to 1. If clr_ovr and a new overrun occur in the same cycle, overrun ends at 1.
- flush, in any state: next cycle is FILL with wr_ptr=0, fill_cnt=0 and tap_cnt=0. A burst in progress is aborted: `sequencing` falls the next cycle and `out_vld` is not issued. A smpl_vld in the same cycle as flush is not written. overrun is unaffected.
- wr_ptr wraps from 2^AW−1 to 0 with no special handling.

## Timing
- Reset values: wr_addr=0, rd_addr=0, sequencing=0, out_vld=0, busy=0, overrun=0, wr_en=0. State is FILL and all counters are 0.
- Reset asserted mid-burst: all outputs go to their reset values immediately (asynchronously).
- An accepted smpl_vld at cycle T that starts a burst gives: `sequencing`=1 for cycles T+1 through T+NTAPS, `out_vld`=1 at T+NTAPS+1, and state IDLE at T+NTAPS+2. The earliest next accepted sample is at T+NTAPS+2.
- rd_addr at cycle T+1+k is start+k mod 2^AW, for k = 0..NTAPS−1.
- `sequencing` and `out_vld` are registered (state-decoded); there are no glitches.
- wr_en is combinational and falls in the same cycle as smpl_vld.

## Test plan
- Reset then fill: 1020 smpl_vld pulses spaced 4 cycles apart → wr_addr 0..1019 with wr_en on each pulse; `sequencing` stays 0.
- First burst: the 1021st pulse at T (wr_addr=1020) → `sequencing` high for T+1..T+1021 with rd_addr 0..1020; `out_vld` only at T+1022; busy high T+1..T+1022.
- Wrap: after 1024 total writes, the next write goes to wr_addr 0. For the burst triggered by the write at wr_addr 3, rd_addr runs 7..1023 then 0..3 (1021 values).
- Overrun: smpl_vld at T+500 inside a burst → no wr_en, wr_addr unchanged, overrun=1 and held. A clr_ovr pulse later → overrun=0.
- Flush mid-burst: flush at T+300 → `sequencing`=0 from T+301, no `out_vld`, wr_addr=0. The next 1020 samples produce no burst, and the 1021st starts one.
- Reset mid-burst: rst pulsed at T+600 → all outputs 0 in the same cycle. After release, the block behaves as from a fresh reset.
